// File: rtl/spi_pkg.sv
// Shared frame layout constants, FSM state type and frame builder for the SPI write master.
package spi_pkg;

  localparam int unsigned FRAME_W   = 16;
  localparam int unsigned WRITE_BIT = 15;
  localparam int unsigned ADDR_MSB  = 14;
  localparam int unsigned ADDR_LSB  = 8;
  localparam int unsigned DATA_MSB  = 7;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    SHIFT,
    GAP
  } state_e;

  // Write frame: {1'b1, addr, data}, transmitted MSB first.
  function automatic logic [FRAME_W-1:0] build_frame(
    input logic [ADDR_MSB-ADDR_LSB:0] addr,
    input logic [DATA_MSB:0]          data
  );
    logic [FRAME_W-1:0] frame;
    frame                    = '0;
    frame[WRITE_BIT]         = 1'b1;
    frame[ADDR_MSB:ADDR_LSB] = addr;
    frame[DATA_MSB:0]        = data;
    return frame;
  endfunction

endpackage

// File: rtl/spi_clk_div.sv
// Half-period counter for the SPI write master; tick marks the last cycle of each half-period.
module spi_clk_div #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  logic [7:0] cnt_q, cnt_d;

  assign tick = en && (cnt_q == 8'(CLK_DIV - 1));

  // Held at zero while disabled so every enable starts a full half-period.
  always_comb begin
    cnt_d = cnt_q;
    if (!en || tick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/spi_write_master.sv
// SPI mode-0 master sending 16-bit register-write frames {1, addr, data}, MSB first.
// Optional sdo readback into rdata is enabled by defining SPI_READBACK_EN.
module spi_write_master
  import spi_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned ADDR_W  = 7,
  parameter int unsigned DATA_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              sdo,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rdata,
  output logic              sclk,
  output logic              sdi,
  output logic              cs
);

  localparam logic [3:0] LastBit = 4'(FRAME_W - 1);

  state_e             state_q, state_d;
  logic [FRAME_W-1:0] shreg_q, shreg_d;
  logic [3:0]         bit_cnt_q, bit_cnt_d;
  logic               sclk_q, sclk_d;
  logic               cs_q, cs_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               div_en;
  logic               tick;

  assign div_en = (state_q != IDLE);

  spi_clk_div #(
    .CLK_DIV(CLK_DIV)
  ) u_clk_div (
    .clk (clk),
    .rst (rst),
    .en  (div_en),
    .tick(tick)
  );

  // sdi is the shift register MSB; shifting in zeros leaves sdi low after the last bit.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    sclk_d    = sclk_q;
    cs_d      = cs_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          shreg_d = build_frame(addr, wdata);
          cs_d    = 1'b0;
          busy_d  = 1'b1;
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (tick) begin
          sclk_d  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (tick) begin
          if (sclk_q) begin
            sclk_d  = 1'b0;
            shreg_d = {shreg_q[FRAME_W-2:0], 1'b0};
          end else if (bit_cnt_q == LastBit) begin
            bit_cnt_d = '0;
            cs_d      = 1'b1;
            state_d   = GAP;
          end else begin
            sclk_d    = 1'b1;
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end
      GAP: begin
        if (tick) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      sclk_q    <= 1'b0;
      cs_q      <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      sclk_q    <= sclk_d;
      cs_q      <= cs_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign sclk = sclk_q;
  assign sdi  = shreg_q[FRAME_W-1];
  assign cs   = cs_q;
  assign busy = busy_q;
  assign done = done_q;

`ifdef SPI_READBACK_EN
  logic              rise_q, rise_d;
  logic [DATA_W-1:0] rx_q, rx_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  // rise_q flags the first high cycle of sclk; sdo is captured at its end.
  always_comb begin
    rise_d  = sclk_d & ~sclk_q;
    rx_d    = rise_q ? {rx_q[DATA_W-2:0], sdo} : rx_q;
    rdata_d = done_d ? rx_d : rdata_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rise_q  <= 1'b0;
      rx_q    <= '0;
      rdata_q <= '0;
    end else begin
      rise_q  <= rise_d;
      rx_q    <= rx_d;
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;
`else
  logic unused_sdo;
  assign unused_sdo = sdo;
  assign rdata      = '0;
`endif

endmodule

// File: tb/tb_spi_write_master.sv
// Scoreboard bench for spi_write_master: peripheral model on the bus, expected frames queued
// by the driver and checked by a monitor on every done pulse.
module tb_spi_write_master;

  localparam int unsigned DIV  = 4;
  localparam int unsigned DIV2 = 2;
  localparam logic [15:0] SDO_PAT = 16'h005A;
`ifdef SPI_READBACK_EN
  localparam logic [7:0] RD_EXP = 8'h5A;
`else
  localparam logic [7:0] RD_EXP = 8'h00;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst   = 1'b1;
  logic       start = 1'b0;
  logic       sdo   = 1'b0;
  logic [6:0] addr  = '0;
  logic [7:0] wdata = '0;
  logic       busy, done, sclk, sdi, cs;
  logic [7:0] rdata;

  logic       start2 = 1'b0;
  logic       sdo2   = 1'b0;
  logic [6:0] addr2  = '0;
  logic [7:0] wdata2 = '0;
  logic       busy2, done2, sclk2, sdi2, cs2;
  logic [7:0] rdata2;

  spi_write_master #(.CLK_DIV(DIV)) u_dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .addr (addr),
    .wdata(wdata),
    .sdo  (sdo),
    .busy (busy),
    .done (done),
    .rdata(rdata),
    .sclk (sclk),
    .sdi  (sdi),
    .cs   (cs)
  );

  spi_write_master #(.CLK_DIV(DIV2)) u_dut2 (
    .clk  (clk),
    .rst  (rst),
    .start(start2),
    .addr (addr2),
    .wdata(wdata2),
    .sdo  (sdo2),
    .busy (busy2),
    .done (done2),
    .rdata(rdata2),
    .sclk (sclk2),
    .sdi  (sdi2),
    .cs   (cs2)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit armed = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Peripheral model for the CLK_DIV=4 instance.
  logic [15:0] rx = '0, last_frame = '0, tx = '0;
  int          rx_n = 0, last_n = 0, gap = 0, fall_cyc = 0, last_rise = 0;
  bit          sclk_p = 1'b0, cs_p = 1'b1, sdi_p = 1'b0, seen = 1'b0;
  logic [7:0]  regs [128] = '{default: 8'h00};

  always @(negedge clk) begin
    if (armed) begin
      if (sdi !== sdi_p) check("sdi_only_on_fall", ((sclk_p && !sclk) || (cs != cs_p)), 1);
      if (!cs && cs_p) begin
        if (seen) check("cs_gap_ge_div", (gap >= DIV), 1);
        rx_n     = 0;
        fall_cyc = cyc;
        sdo      = SDO_PAT[15];
        tx       = SDO_PAT << 1;
      end
      if (!cs && sclk && !sclk_p) begin
        if (rx_n == 0) check("first_rise", cyc - fall_cyc, DIV);
        else           check("rise_spacing", cyc - last_rise, 2 * DIV);
        rx        = {rx[14:0], sdi};
        rx_n++;
        last_rise = cyc;
      end
      if (!cs && !sclk && sclk_p) begin
        sdo = tx[15];
        tx  = tx << 1;
      end
      if (cs && !cs_p) begin
        last_frame = rx;
        last_n     = rx_n;
        seen       = 1'b1;
        if (rx_n == 16 && rx[15]) regs[rx[14:8]] = rx[7:0];
      end
      gap    = cs ? gap + 1 : 0;
      sclk_p = sclk;
      cs_p   = cs;
      sdi_p  = sdi;
    end
  end

  // Receiver for the CLK_DIV=2 instance.
  logic [15:0] rx2 = '0;
  int          rx2_n = 0;
  bit          sclk2_p = 1'b0, cs2_p = 1'b1, sdi2_p = 1'b0;

  always @(negedge clk) begin
    if (armed) begin
      if (sdi2 !== sdi2_p) check("sdi2_only_on_fall", ((sclk2_p && !sclk2) || (cs2 != cs2_p)), 1);
      if (!cs2 && cs2_p) rx2_n = 0;
      if (!cs2 && sclk2 && !sclk2_p) begin
        rx2 = {rx2[14:0], sdi2};
        rx2_n++;
      end
      sclk2_p = sclk2;
      cs2_p   = cs2;
      sdi2_p  = sdi2;
    end
  end

  typedef struct {
    logic [15:0] frame;
    int          done_cyc;
  } exp_t;

  exp_t expq[$];
  exp_t mon_e;
  int   busy_cnt = 0;

  always @(negedge clk) begin
    if (armed) begin
      if (busy) busy_cnt++;
      if (done) begin
        if (expq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done: got done=1 expected 0 (cycle %0d)", cyc);
        end else begin
          mon_e = expq.pop_front();
          check("frame", last_frame, mon_e.frame);
          check("frame_bits", last_n, 16);
          check("done_cycle", cyc, mon_e.done_cyc);
          check("busy_cycles", busy_cnt, 34 * DIV);
          check("rdata", rdata, RD_EXP);
          check("busy_low_at_done", busy, 0);
        end
      end
      if (!busy) busy_cnt = 0;
    end
  end

  task automatic send(input logic [6:0] a, input logic [7:0] d);
    exp_t e;
    e.frame    = {1'b1, a, d};
    e.done_cyc = cyc + 34 * DIV + 1;
    expq.push_back(e);
    start = 1'b1;
    addr  = a;
    wdata = d;
    @(negedge clk);
    start = 1'b0;
    addr  = ~a;
    wdata = ~d;
  endtask

  task automatic wait_done(input string name);
    int i;
    i = 0;
    while (!done && i < 400) begin
      @(negedge clk);
      i++;
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: got done=0 expected 1 within 400 cycles", name);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected test end");
    $fatal(1, "watchdog");
  end

  int t0;

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_cs", cs, 1);
    check("rst_sclk", sclk, 0);
    check("rst_sdi", sdi, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rdata", rdata, 0);
    check("rst_cs2", cs2, 1);
    armed = 1'b1;
    repeat (2) @(negedge clk);

    // Single frame with detailed timing
    t0 = cyc;
    send(7'h03, 8'hA5);
    check("cs_low_t1", cs, 0);
    check("busy_t1", busy, 1);
    check("sdi_msb_t1", sdi, 1);
    check("sclk_t1", sclk, 0);
    repeat (DIV - 1) @(negedge clk);
    check("sclk_low_setup_end", sclk, 0);
    @(negedge clk);
    check("sclk_first_high", sclk, 1);
    repeat (t0 + 33 * DIV - cyc) @(negedge clk);
    check("cs_low_last", cs, 0);
    @(negedge clk);
    check("cs_high_gap", cs, 1);
    check("sdi_zero_gap", sdi, 0);
    check("busy_in_gap", busy, 1);
    wait_done("frame1");
    check("frame_83a5", last_frame, 16'h83A5);

    // Back-to-back, second start in the done cycle
    repeat (3) @(negedge clk);
    send(7'h01, 8'h3C);
    wait_done("b2b_first");
    send(7'h05, 8'hFF);
    wait_done("b2b_second");
    repeat (2) @(negedge clk);
    check("reg1", regs[1], 8'h3C);
    check("reg5", regs[5], 8'hFF);

    // start during a frame is ignored
    t0 = cyc;
    send(7'h12, 8'h34);
    repeat (19) @(negedge clk);
    start = 1'b1;
    addr  = 7'h55;
    wdata = 8'h66;
    @(negedge clk);
    start = 1'b0;
    wait_done("ignore");
    repeat (40 * DIV) @(negedge clk);
    check("idle_after_ignore", busy, 0);
    check("reg12", regs[7'h12], 8'h34);
    check("reg55_untouched", regs[7'h55], 0);

    // Reset mid-SHIFT aborts the frame
    t0 = cyc;
    send(7'h22, 8'h11);
    repeat (49) @(negedge clk);
    rst = 1'b1;
    expq.delete();
    @(negedge clk);
    rst = 1'b0;
    check("abort_cs", cs, 1);
    check("abort_sclk", sclk, 0);
    check("abort_sdi", sdi, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    repeat (40 * DIV) @(negedge clk);
    check("abort_no_write", regs[7'h22], 0);
    send(7'h22, 8'h11);
    wait_done("after_reset");
    check("reg22_after_reset", regs[7'h22], 8'h11);

    // CLK_DIV=2 instance
    t0     = cyc;
    start2 = 1'b1;
    addr2  = 7'h2A;
    wdata2 = 8'hC3;
    @(negedge clk);
    start2 = 1'b0;
    for (int i = 0; i < 300 && !done2; i++) @(negedge clk);
    check("div2_done_cycle", cyc - t0, 34 * DIV2 + 1);
    check("div2_frame", rx2, 16'hAAC3);
    check("div2_bits", rx2_n, 16);

    repeat (10) @(negedge clk);
    check("queue_drained", expq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_write_master.md
Name: spi_write_master

Overview:
- SPI controller that drives 16-bit register-write frames into the on-chip SPI register peripheral (`sclk`/`sdi`/`cs` receive side).
- Used by test/config logic to program peripheral registers from the system clock domain.
- Frame format, MSB first: bit15 = 1 (write), bits14:8 = address, bits7:0 = data.
- SPI mode 0: `sclk` idles low, `cs` active-low.

Parameters:
- CLK_DIV, 4, system clocks per `sclk` half-period; legal range 2..255. The minimum of 2 covers the receiver's 2-flop `sclk` synchronizer.
- ADDR_W, 7, address field width; fixed by frame format.
- DATA_W, 8, data field width; fixed by frame format.

Ports:
- clk  in  1  system clock; all logic on posedge
- rst  in  1  reset, synchronous, active-high
- start  in  1  request a frame; accepted when busy=0
- addr  in  ADDR_W  register address, captured on accept
- wdata  in  DATA_W  write data, captured on accept
- sdo  in  1  serial data from peripheral; used only with SPI_READBACK_EN
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse at frame completion
- rdata  out  DATA_W  last 8 bits sampled on sdo; 0 without the feature
- sclk  out  1  SPI clock
- sdi  out  1  serial data to peripheral
- cs  out  1  chip select, active-low

Behaviour:
- Reset values: cs=1, sclk=0, sdi=0, busy=0, done=0, rdata=0, state=IDLE, all counters 0. All outputs are registered.
- Reset asserted mid-frame aborts the frame. The next cycle shows reset values. No done pulse.
- States: IDLE -> SETUP -> SHIFT -> GAP -> IDLE.
- IDLE:
  - start=1 at cycle T latches shreg={1'b1, addr, wdata}.
  - At T+1: cs=0, busy=1, sdi=shreg[15], state=SETUP.
- SETUP:
  - Lasts CLK_DIV cycles (T+1 .. T+CLK_DIV); sclk=0.
  - Then sclk rises at T+1+CLK_DIV.
- SHIFT, per bit n=0..15 (MSB first):
  - High phase: CLK_DIV cycles starting at T+1+CLK_DIV*(1+2n).
  - Low phase: the following CLK_DIV cycles.
  - sdi changes only in the cycle sclk falls, to the next bit, so sdi is stable across each rising edge.
  - After bit 15 falls, sdi=0. Bit counter 0..15 and half-period counter 0..CLK_DIV-1 both wrap to 0 on exit.
- GAP:
  - cs rises at T+1+33*CLK_DIV and stays high for CLK_DIV cycles.
  - At T+1+34*CLK_DIV: done=1 for one cycle, busy=0, state=IDLE.
- start while busy=1 is ignored. No queueing; addr/wdata changes mid-frame have no effect.
- start in the done cycle is accepted (busy=0), giving back-to-back frames with a cs-high gap of at least CLK_DIV cycles.
- Total frame time is 34*CLK_DIV+1 cycles from accept to done; with CLK_DIV=4, done lands at T+137.
- Address and data are not range-checked; the peripheral discards unsupported addresses.

Optional Feature:
- Macro: SPI_READBACK_EN.
- Defined:
  - sdo is sampled into an 8-bit shift register in the cycle sclk rises, for every bit.
  - rdata is loaded from that register in the done cycle and holds until the next done or rst.
- Undefined: sdo is ignored, no sampling register exists, rdata is constant 0.

Decomposition:
- Package spi_pkg holds:
  - FRAME_W=16, WRITE_BIT=15, ADDR_MSB=14, ADDR_LSB=8, DATA_MSB=7
  - state enum {IDLE, SETUP, SHIFT, GAP}
- Sub-module spi_clk_div:
  - Half-period counter, parameter CLK_DIV, inputs clk/rst/en.
  - Output tick: 1 on the last cycle of each half-period.
  - Counter restarts from 0 when en rises.
- The top FSM advances phases on tick.

Test Plan:
- CLK_DIV=4; rst, then start at cycle T with addr=7'h03, wdata=8'hA5 -> cs low at T+1; 16 sclk rises at T+5+8n; bits sampled on rising edges = 16'h83A5; cs high at T+133; done pulse at T+137; busy high T+1..T+136.
- Behavioural model of the peripheral connected; write addr=1 data=8'h3C, then addr=5 data=8'hFF back-to-back (second start in the done cycle) -> reg1=8'h3C, reg5=8'hFF; cs-high gap between frames ≥ 4 cycles.
- start pulsed at T+20 during a frame with different addr/wdata -> ignored; frame bits unchanged; exactly one done.
- rst asserted at T+50 (mid-SHIFT) -> next cycle cs=1, sclk=0, sdi=0, busy=0; no done; a new start then produces a complete correct frame.
- CLK_DIV=2 -> sclk period 4 cycles; done at T+69; sdi transitions only in sclk-falling cycles (assertion).
- SPI_READBACK_EN defined, sdo driven with 16'h005A aligned to sclk rises -> rdata=8'h5A from the done cycle. Macro undefined, same stimulus -> rdata=0.
